// File: rtl/definitions_pkg.sv
// Shared UART definitions: transmitter oversampling factor, feeder FIFO depth and feeder FSM states.
package definitions_pkg;

   localparam int OVERSAMPLE    = 16;
   localparam int TX_FIFO_DEPTH = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } feeder_state_t;

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers and a separate occupancy counter, so full and empty
// never alias. Push while full and pop while empty are ignored. The head is visible combinationally.
module sync_fifo
   import definitions_pkg::*;
#(
   parameter int DEPTH  = TX_FIFO_DEPTH,
   parameter int DATA_W = 8
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LEVEL_FULL = DEPTH[AW:0];

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (level == LEVEL_FULL);
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage carries no reset; only the pointers and level decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue and launch controller in front of the UART transmitter: buffers host bytes and
// launches one frame per tx_done. Define UART_TX_FEEDER_OVF_EN to add the sticky ovf flag and ovf_clr.
module uart_tx_feeder
   import definitions_pkg::*;
#(
   parameter int DEPTH  = TX_FIFO_DEPTH,
   parameter int DATA_W = 8
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic [DATA_W-1:0]        tx_din,
   output logic                     tx_start,
   input  logic                     tx_done,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty
`ifdef UART_TX_FEEDER_OVF_EN
   ,
   output logic                     ovf,
   input  logic                     ovf_clr
`endif
);

   feeder_state_t     state;
   logic              full;
   logic              launch;
   logic [DATA_W-1:0] head;

   sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_valid),
      .push_data (wr_data),
      .pop       (launch),
      .head      (head),
      .level     (level),
      .full      (full),
      .empty     (empty)
   );

   assign wr_ready = !full;

   // A frame starts from IDLE as soon as data exists, or back-to-back on the transmitter's done pulse.
   assign launch = !empty && ((state == IDLE) || tx_done);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tx_start <= 1'b0;
         tx_din   <= '0;
         busy     <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            IDLE: begin
               if (launch) begin
                  tx_din   <= head;
                  tx_start <= 1'b1;
                  busy     <= 1'b1;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (tx_done) begin
                  if (launch) begin
                     tx_din   <= head;
                     tx_start <= 1'b1;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UART_TX_FEEDER_OVF_EN
   always_ff @(posedge clk) begin
      if (rst || ovf_clr) begin
         ovf <= 1'b0;
      end else if (wr_valid && !wr_ready) begin
         ovf <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: hand-derived vector table, directed corner sequences and
// randomized traffic against a queue-based reference model. Honours UART_TX_FEEDER_OVF_EN.
module tb_uart_tx_feeder;

   localparam int DEPTH  = 16;
   localparam int DATA_W = 8;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] tx_din;
   logic              tx_start;
   logic              tx_done;
   logic              busy;
   logic [LW-1:0]     level;
   logic              empty;
`ifdef UART_TX_FEEDER_OVF_EN
   logic              ovf;
   logic              ovf_clr;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx_feeder #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .tx_din   (tx_din),
      .tx_start (tx_start),
      .tx_done  (tx_done),
      .busy     (busy),
      .level    (level),
      .empty    (empty)
`ifdef UART_TX_FEEDER_OVF_EN
      ,
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
`endif
   );

   // Reference model: a byte queue plus "frame in flight" flag.
   logic [7:0] mq[$];
   bit         m_busy;
   bit         m_start;
   logic [7:0] m_din;
   bit         m_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit wv, input logic [7:0] wd, input bit td,
                             input bit clr);
      bit launch;
      bit accept;
      bit overflow;
      if (r) begin
         mq.delete();
         m_busy  = 0;
         m_start = 0;
         m_din   = 8'h00;
         m_ovf   = 0;
      end else begin
         accept   = wv && (mq.size() < DEPTH);
         overflow = wv && (mq.size() >= DEPTH);
         launch   = 0;
         if (!m_busy) launch = (mq.size() > 0);
         else if (td) begin
            if (mq.size() > 0) launch = 1;
            else m_busy = 0;
         end
         m_start = 0;
         if (launch) begin
            m_din   = mq.pop_front();
            m_start = 1;
            m_busy  = 1;
         end
         if (accept) mq.push_back(wd);
         if (clr) m_ovf = 0;
         else if (overflow) m_ovf = 1;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".tx_start"}, 32'(tx_start), 32'(m_start));
      check({tag, ".tx_din"},   32'(tx_din),   32'(m_din));
      check({tag, ".busy"},     32'(busy),     32'(m_busy));
      check({tag, ".level"},    32'(level),    32'(mq.size()));
      check({tag, ".empty"},    32'(empty),    32'(mq.size() == 0));
      check({tag, ".wr_ready"}, 32'(wr_ready), 32'(mq.size() < DEPTH));
`ifdef UART_TX_FEEDER_OVF_EN
      check({tag, ".ovf"},      32'(ovf),      32'(m_ovf));
`endif
   endtask

   task automatic cycle(input bit r, input bit wv, input logic [7:0] wd, input bit td,
                        input bit clr, input bit cmp, input string tag);
      rst      = r;
      wr_valid = wv;
      wr_data  = wd;
      tx_done  = td;
`ifdef UART_TX_FEEDER_OVF_EN
      ovf_clr  = clr;
`endif
      @(posedge clk);
      model_edge(r, wv, wd, td, clr);
      #1;
      if (cmp) compare_all(tag);
   endtask

   typedef struct {
      bit         r;
      bit         wv;
      logic [7:0] wd;
      bit         td;
      bit         e_start;
      logic [7:0] e_din;
      bit         e_busy;
      int         e_level;
      bit         e_empty;
      bit         e_ready;
   } vec_t;

   vec_t vecs[8];
   int   cnt;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_data = '0; tx_done = 1'b0;
`ifdef UART_TX_FEEDER_OVF_EN
      ovf_clr = 1'b0;
`endif
      m_busy = 0; m_start = 0; m_din = 8'h00; m_ovf = 0;

      vecs[0] = '{1, 0, 8'h00, 0,  0, 8'h00, 0, 0, 1, 1};
      vecs[1] = '{0, 1, 8'hA5, 0,  0, 8'h00, 0, 1, 0, 1};
      vecs[2] = '{0, 0, 8'h00, 0,  1, 8'hA5, 1, 0, 1, 1};
      vecs[3] = '{0, 0, 8'h00, 0,  0, 8'hA5, 1, 0, 1, 1};
      vecs[4] = '{0, 1, 8'h3C, 0,  0, 8'hA5, 1, 1, 0, 1};
      vecs[5] = '{0, 0, 8'h00, 1,  1, 8'h3C, 1, 0, 1, 1};
      vecs[6] = '{0, 0, 8'h00, 1,  0, 8'h3C, 0, 0, 1, 1};
      vecs[7] = '{0, 0, 8'h00, 1,  0, 8'h3C, 0, 0, 1, 1};

      for (int i = 0; i < 8; i++) begin
         cycle(vecs[i].r, vecs[i].wv, vecs[i].wd, vecs[i].td, 0, 0, "vec");
         check($sformatf("vec%0d.tx_start", i), 32'(tx_start), 32'(vecs[i].e_start));
         check($sformatf("vec%0d.tx_din", i),   32'(tx_din),   32'(vecs[i].e_din));
         check($sformatf("vec%0d.busy", i),     32'(busy),     32'(vecs[i].e_busy));
         check($sformatf("vec%0d.level", i),    32'(level),    32'(vecs[i].e_level));
         check($sformatf("vec%0d.empty", i),    32'(empty),    32'(vecs[i].e_empty));
         check($sformatf("vec%0d.wr_ready", i), 32'(wr_ready), 32'(vecs[i].e_ready));
      end

      // Single byte, then no tx_done for 100 cycles: exactly one launch.
      cycle(0, 1, 8'hA5, 0, 0, 1, "single.wr");
      cycle(0, 0, 8'h00, 0, 0, 1, "single.launch");
      check("single.start", 32'(tx_start), 32'd1);
      check("single.din",   32'(tx_din),   32'hA5);
      check("single.level", 32'(level),    32'd0);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         cycle(0, 0, 8'h00, 0, 0, 1, "single.hold");
         if (tx_start) cnt++;
      end
      check("single.extra_starts", 32'(cnt), 32'd0);
      cycle(0, 0, 8'h00, 1, 0, 1, "single.done");
      check("single.idle_busy", 32'(busy), 32'd0);

      // Three back-to-back bytes, tx_done spaced 20 cycles apart.
      cycle(0, 1, 8'h01, 0, 0, 1, "b2b.w1");
      cycle(0, 1, 8'h02, 0, 0, 1, "b2b.w2");
      check("b2b.first_din", 32'(tx_din), 32'h01);
      cycle(0, 1, 8'h03, 0, 0, 1, "b2b.w3");
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 19; i++) cycle(0, 0, 8'h00, 0, 0, 1, "b2b.wait");
         cycle(0, 0, 8'h00, 1, 0, 1, "b2b.done");
         if (k < 2) begin
            check($sformatf("b2b.start%0d", k), 32'(tx_start), 32'd1);
            check($sformatf("b2b.din%0d", k),   32'(tx_din),   32'(8'h02 + k));
         end else begin
            check("b2b.final_busy",  32'(busy),  32'd0);
            check("b2b.final_empty", 32'(empty), 32'd1);
         end
      end

      // Fill to full with the FSM stalled; the extra 0xFF must be dropped.
      for (int i = 0; i <= 16; i++) cycle(0, 1, 8'(i), 0, 0, 1, "fill.wr");
      check("fill.level", 32'(level),    32'd16);
      check("fill.ready", 32'(wr_ready), 32'd0);
      cycle(0, 1, 8'hFF, 0, 0, 1, "fill.drop");
      check("fill.level_after_drop", 32'(level), 32'd16);
      for (int i = 1; i <= 16; i++) begin
         cycle(0, 0, 8'h00, 1, 0, 1, "fill.drain");
         check($sformatf("fill.start%0d", i), 32'(tx_start), 32'd1);
         check($sformatf("fill.din%0d", i),   32'(tx_din),   32'(i));
      end
      cycle(0, 0, 8'h00, 1, 0, 1, "fill.end");
      check("fill.end_busy", 32'(busy), 32'd0);

      // Push and pop in the same edge at level 5.
      for (int i = 0; i < 6; i++) cycle(0, 1, 8'(8'h50 + i), 0, 0, 1, "pp.wr");
      check("pp.level_before", 32'(level), 32'd5);
      cycle(0, 1, 8'h60, 1, 0, 1, "pp.both");
      check("pp.level_same", 32'(level),  32'd5);
      check("pp.din",        32'(tx_din), 32'h51);
      for (int i = 2; i <= 6; i++) begin
         cycle(0, 0, 8'h00, 1, 0, 1, "pp.drain");
         check($sformatf("pp.order%0d", i), 32'(tx_din), (i == 6) ? 32'h60 : 32'(8'h50 + i));
      end
      cycle(0, 0, 8'h00, 1, 0, 1, "pp.end");

      // Reset while busy with 7 queued bytes; a later tx_done must not launch.
      for (int i = 0; i < 8; i++) cycle(0, 1, 8'(8'h70 + i), 0, 0, 1, "rst.wr");
      check("rst.level_before", 32'(level), 32'd7);
      cycle(1, 0, 8'h00, 0, 0, 1, "rst.apply");
      check("rst.level", 32'(level),    32'd0);
      check("rst.start", 32'(tx_start), 32'd0);
      check("rst.busy",  32'(busy),     32'd0);
      check("rst.ready", 32'(wr_ready), 32'd1);
      cycle(0, 0, 8'h00, 1, 0, 1, "rst.spurious");
      check("rst.no_launch", 32'(tx_start), 32'd0);

`ifdef UART_TX_FEEDER_OVF_EN
      for (int i = 0; i < 17; i++) cycle(0, 1, 8'(i), 0, 0, 1, "ovf.fill");
      check("ovf.pre", 32'(ovf), 32'd0);
      cycle(0, 1, 8'hEE, 0, 0, 1, "ovf.set");
      check("ovf.set", 32'(ovf), 32'd1);
      for (int i = 0; i < 50; i++) cycle(0, 0, 8'h00, 0, 0, 1, "ovf.hold");
      check("ovf.sticky", 32'(ovf), 32'd1);
      cycle(0, 0, 8'h00, 0, 1, 1, "ovf.clr");
      check("ovf.cleared", 32'(ovf), 32'd0);
      cycle(0, 1, 8'hEE, 0, 1, 1, "ovf.both");
      check("ovf.clr_priority", 32'(ovf), 32'd0);
      cycle(1, 0, 8'h00, 0, 0, 1, "ovf.rst");
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 1) == 1),
               8'($urandom),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 63) == 0),
               1, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte buffer and launch controller that sits directly upstream of the UART transmitter. It accepts bytes from the system side with a valid/ready handshake and stores them in an internal FIFO. It drains them one frame at a time into the transmitter by driving its din/tx_start inputs and consuming its tx_done pulse. The transmitter and the host are decoupled, so bursts of up to DEPTH bytes are absorbed without back-pressure.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
DATA_W, 8, byte width; must match transmitter din width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_data  in  DATA_W  byte to queue
wr_valid  in  1  host offers wr_data this cycle
wr_ready  out  1  FIFO can accept; equals !full
tx_din  out  DATA_W  to transmitter din; registered
tx_start  out  1  to transmitter tx_start; registered, single-cycle pulse
tx_done  in  1  from transmitter; one-cycle pulse at end of stop bit
busy  out  1  a frame is launched and tx_done is not yet seen
level  out  $clog2(DEPTH)+1  current FIFO occupancy
empty  out  1  level == 0

Behaviour:
- Reset (rst=1 at posedge): FIFO pointers and level cleared; state IDLE; tx_start=0, tx_din=0, busy=0, wr_ready=1, empty=1, level=0. Reset mid-frame discards queued data. The transmitter is reset by the same rst, so no frame is completed.
- Push: a byte is written when wr_valid && wr_ready at a posedge. Writes while full are ignored; there is no error path unless the optional feature is enabled.
- Pop: the head is popped at the same posedge that loads tx_din and sets tx_start.
- Simultaneous push and pop: both occur and level is unchanged. When full, wr_ready=0 that cycle even if a pop occurs, because it is derived from registered level.
- Pointers wrap modulo DEPTH. Level is tracked separately, so full and empty are unambiguous.
- FSM states: IDLE, BUSY.
  - IDLE: if !empty, then at the next edge: pop, tx_din<=head, tx_start<=1, busy<=1, go to BUSY. Otherwise stay in IDLE.
  - BUSY: tx_start returns to 0 after one cycle.
    - On tx_done with FIFO non-empty: relaunch at that edge (pop, tx_din<=head, tx_start<=1) and stay in BUSY. tx_start is high in the cycle after tx_done, when the transmitter has just re-entered its idle state.
    - On tx_done with FIFO empty: busy<=0, go to IDLE.
- Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE gives tx_start high in the cycle after edge N+1.
- tx_din is held stable from launch until the next launch.
- tx_done seen in IDLE is ignored. A spurious pulse must not pop.

Optional Feature:
Macro UART_TX_FEEDER_OVF_EN.
- Defined: adds output ovf (1 bit, sticky) and input ovf_clr (1 bit).
  - ovf sets at the edge where wr_valid && !wr_ready.
  - ovf clears on ovf_clr or rst; ovf_clr has priority over a simultaneous set.
- Undefined: both ports are absent and dropped writes are silent.

Decomposition:
- definitions_pkg gains:
  - TX_FIFO_DEPTH constant (default 16), used as the DEPTH default;
  - feeder_state_t enum {IDLE, BUSY} on a 1-bit logic base.
- The transmitter keeps using the existing OVERSAMPLE from the same package.
- Sub-module sync_fifo (DEPTH, DATA_W): storage, pointers, level, full/empty, push/pop ports.
- uart_tx_feeder instantiates sync_fifo and holds only the FSM and output registers.

Test Plan:
- After reset, write 0xA5 -> tx_start high exactly one cycle, tx_din=0xA5, busy=1, level returns to 0. Hold tx_done low 100 cycles -> no further tx_start.
- Write 0x01,0x02,0x03 back-to-back, then pulse tx_done three times spaced 20 cycles apart:
  - tx_start follows each tx_done by exactly one cycle with tx_din 0x02, then 0x03;
  - after the third tx_done: busy=0, empty=1.
- Fill 16 bytes with the FSM stalled (no tx_done) -> level=16 after the first pop refills, wr_ready=0. A 17th write of 0xFF is dropped; drain and check the exact 0x00..0x0F-style sequence with no 0xFF.
- Push and pop in the same cycle at level=5 -> level stays 5 and the data order is preserved.
- Assert rst mid-BUSY with level=7 -> next cycle level=0, tx_start=0, busy=0, wr_ready=1. A tx_done pulse afterwards causes no launch.
- With UART_TX_FEEDER_OVF_EN: overflow sets ovf. ovf stays set across 50 cycles, clears on ovf_clr. Simultaneous overflow and ovf_clr -> ovf=0.
